seq_alu: RTL and testbench

//  Parametrised, clocked ALU: one opcode-selected operation per transaction on WIDTH-bit operands.

---
 rtl/seq_alu.sv | 160 ++++++++++++++++
 tb/tb_seq_alu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Clocked ALU behind a start/ready/done handshake. Logic, shift, add and subtract
// finish in one cycle; multiply (shift-add) and divide (restoring) take WIDTH steps.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 carry_in,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry_out,
    output logic                 div_by_zero,
    output logic                 bad_op
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL_IT = 2'd1;
    localparam logic [1:0] DIV_IT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   work;

    logic [2*WIDTH-1:0]   imm_result;
    logic                 imm_carry;
    logic                 imm_dbz;
    logic                 imm_bad;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    assign ready = (state == IDLE) && !reset;
    assign done  = (state == DONE);

    assign sum_ext  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
    assign diff_ext = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        imm_result = '0;
        imm_carry  = 1'b0;
        imm_dbz    = 1'b0;
        imm_bad    = 1'b0;
        case (op)
            4'd0: imm_result[WIDTH-1:0] = A & B;
            4'd1: imm_result[WIDTH-1:0] = ~(A & B);
            4'd2: imm_result[WIDTH-1:0] = A | B;
            4'd3: imm_result[WIDTH-1:0] = ~(A | B);
            4'd4: imm_result[WIDTH-1:0] = A ^ B;
            4'd5: imm_result[WIDTH-1:0] = ~(A ^ B);
            4'd6: imm_result[WIDTH-1:0] = ~A;
            4'd7: begin
                imm_result[WIDTH-1:0] = {A[WIDTH-2:0], 1'b0};
                imm_carry             = A[WIDTH-1];
            end
            4'd8: begin
                imm_result[WIDTH-1:0] = sum_ext[WIDTH-1:0];
                imm_carry             = sum_ext[WIDTH];
            end
            4'd9: begin
                imm_result[WIDTH-1:0] = diff_ext[WIDTH-1:0];
                imm_carry             = diff_ext[WIDTH];
            end
            4'd10: imm_result = '0;
            // Only reached for a zero divisor; a non-zero divisor goes to DIV_IT
            4'd11: begin
                imm_result = {A, {WIDTH{1'b1}}};
                imm_dbz    = 1'b1;
            end
            default: imm_bad = 1'b1;
        endcase
    end

    // work holds {partial product high, multiplier remaining} during MUL and
    // {remainder, dividend/quotient} during DIV
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        div_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work        <= '0;
            result      <= '0;
            carry_out   <= 1'b0;
            div_by_zero <= 1'b0;
            bad_op      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q         <= A;
                        b_q         <= B;
                        carry_out   <= 1'b0;
                        div_by_zero <= 1'b0;
                        bad_op      <= 1'b0;
                        if (op == 4'd10) begin
                            work  <= {{WIDTH{1'b0}}, B};
                            cnt   <= CNT_W'(WIDTH);
                            state <= MUL_IT;
                        end else if (op == 4'd11 && B != '0) begin
                            work  <= {{WIDTH{1'b0}}, A};
                            cnt   <= CNT_W'(WIDTH);
                            state <= DIV_IT;
                        end else begin
                            result      <= imm_result;
                            carry_out   <= imm_carry;
                            div_by_zero <= imm_dbz;
                            bad_op      <= imm_bad;
                            state       <= DONE;
                        end
                    end
                end
                MUL_IT: begin
                    work <= mul_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result <= mul_next;
                        state  <= DONE;
                    end
                end
                DIV_IT: begin
                    work <= div_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result <= div_next;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): vector table, random model-checked
// transactions, and hand sequences for busy-start, isolation and mid-iteration reset.
module tb_seq_alu;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] res;
        logic       cout;
        logic       dbz;
        logic       bad;
        int         lat;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       div_by_zero;
    logic       bad_op;

    int   checks;
    int   errors;
    vec_t sb_q[$];
    vec_t tbl[$];

    seq_alu #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .A(a),
        .B(b),
        .carry_in(carry_in),
        .ready(ready),
        .done(done),
        .result(result),
        .carry_out(carry_out),
        .div_by_zero(div_by_zero),
        .bad_op(bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [3:0] av, input logic [3:0] bv,
                                input logic ci, input logic [7:0] r, input logic co,
                                input logic dz, input logic bo, input int l);
        vec_t v;
        v.op = o; v.a = av; v.b = bv; v.cin = ci;
        v.res = r; v.cout = co; v.dbz = dz; v.bad = bo; v.lat = l;
        return v;
    endfunction

    // Arithmetic reference model written with integer operators
    function automatic vec_t model(input logic [3:0] o, input logic [3:0] av,
                                   input logic [3:0] bv, input logic ci);
        vec_t v;
        int   s;
        v = mk(o, av, bv, ci, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        case (o)
            4'd0: v.res = {4'h0, av & bv};
            4'd1: v.res = {4'h0, ~(av & bv)};
            4'd2: v.res = {4'h0, av | bv};
            4'd3: v.res = {4'h0, ~(av | bv)};
            4'd4: v.res = {4'h0, av ^ bv};
            4'd5: v.res = {4'h0, ~(av ^ bv)};
            4'd6: v.res = {4'h0, ~av};
            4'd7: begin
                s      = (int'(av) * 2) % 16;
                v.res  = 8'(s);
                v.cout = av[3];
            end
            4'd8: begin
                s      = int'(av) + int'(bv) + int'(ci);
                v.res  = 8'(s % 16);
                v.cout = (s >= 16);
            end
            4'd9: begin
                v.cout = (int'(av) < int'(bv) + int'(ci));
                v.res  = 8'((int'(av) - int'(bv) - int'(ci) + 32) % 16);
            end
            4'd10: begin
                v.res = 8'(int'(av) * int'(bv));
                v.lat = 5;
            end
            4'd11: begin
                if (bv == 4'd0) begin
                    v.res = {av, 4'hF};
                    v.dbz = 1'b1;
                end else begin
                    v.res = 8'((int'(av) % int'(bv)) * 16 + int'(av) / int'(bv));
                    v.lat = 5;
                end
            end
            default: v.bad = 1'b1;
        endcase
        return v;
    endfunction

    // Called on a negedge with the DUT idle; returns just after the accept edge
    task automatic applyStimulus(input vec_t v);
        check("ready_before_accept", 32'(ready), 32'd1);
        op       = v.op;
        a        = v.a;
        b        = v.b;
        carry_in = v.cin;
        start    = 1'b1;
        @(posedge clk);
        sb_q.push_back(v);
        #1;
        start    = 1'b0;
        op       = 4'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
        carry_in = 1'($urandom);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        int   lat;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
        end
        e = sb_q.pop_front();
        if (done !== 1'b1) begin
            check({tag, "_done_timeout"}, 32'(done), 32'd1);
        end else begin
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_carry_out"}, 32'(carry_out), 32'(e.cout));
            check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
            check({tag, "_bad_op"}, 32'(bad_op), 32'(e.bad));
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_ready_after_done"}, 32'(ready), 32'd1);
            check({tag, "_result_held"}, 32'(result), 32'(e.res));
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        applyStimulus(v);
        checkOutput(tag);
    endtask

    initial begin
        vec_t v;
        int   lat;
        logic saw_done;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 4'd0;
        a        = 4'd0;
        b        = 4'd0;
        carry_in = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {29'd0, carry_out, div_by_zero, bad_op}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 32'(ready), 32'd1);
        @(negedge clk);

        // op, A, B, cin, result, carry_out, div_by_zero, bad_op, latency
        tbl.push_back(mk(4'd8,  4'hC, 4'h3, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd9,  4'h3, 4'h1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd9,  4'h6, 4'h9, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd10, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd11, 4'hA, 4'h3, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd11, 4'h6, 4'h0, 1'b0, 8'h6F, 1'b0, 1'b1, 1'b0, 1));
        tbl.push_back(mk(4'd13, 4'h5, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1));
        tbl.push_back(mk(4'd0,  4'hA, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd1,  4'hA, 4'hC, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd2,  4'h9, 4'h4, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd3,  4'h9, 4'h4, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd4,  4'hA, 4'h5, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd5,  4'hA, 4'h6, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd6,  4'h5, 4'h0, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd7,  4'h9, 4'h0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd10, 4'h7, 4'h3, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd10, 4'h0, 4'h9, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd11, 4'hF, 4'h1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd11, 4'h2, 4'h7, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd11, 4'hF, 4'hF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 5));
        tbl.push_back(mk(4'd8,  4'hF, 4'h0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd8,  4'h5, 4'h2, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd9,  4'h0, 4'h0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd9,  4'h0, 4'hF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'd15, 4'hF, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1));

        foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            v = model(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom));
            run_txn(v, $sformatf("rand%0d_op%0d", i, v.op));
        end

        // MUL with start held high and inputs changing while busy
        check("ready_before_busy_mul", 32'(ready), 32'd1);
        op = 4'd10; a = 4'hF; b = 4'hF; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        op = 4'd8; a = 4'h1; b = 4'h1; carry_in = 1'b1;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) break;
            check($sformatf("busy_ready_c%0d", lat), 32'(ready), 32'd0);
        end
        start = 1'b0;
        check("busy_mul_done", 32'(done), 32'd1);
        check("busy_mul_result", 32'(result), 32'hE1);
        check("busy_mul_latency", 32'(lat), 32'd5);
        @(negedge clk);
        check("busy_mul_no_requeue", 32'(done), 32'd0);
        check("busy_mul_result_held", 32'(result), 32'hE1);

        // Reset two cycles into a MUL aborts it without a done pulse
        applyStimulus(mk(4'd10, 4'h7, 4'h3, 1'b0, 8'h15, 1'b0, 1'b0, 1'b0, 5));
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        reset = 1'b1;
        #1;
        check("mid_reset_ready", 32'(ready), 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("mid_reset_result", 32'(result), 32'd0);
        check("mid_reset_flags", {29'd0, carry_out, div_by_zero, bad_op}, 32'd0);
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("post_reset_ready", 32'(ready), 32'd1);
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("aborted_no_done", 32'(saw_done), 32'd0);
        run_txn(mk(4'd4, 4'hA, 4'h5, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1), "post_reset_xor");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
